// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory programmer.
// Collects a byte stream (valid/ready), packs bytes little-endian into
// 32-bit words and issues one single-cycle write per word. The core is held
// for the whole session, and a session ends after TIMEOUT idle cycles.
module imem_loader #(
    parameter int DEPTH   = 1024,
    parameter int AW      = 10,
    parameter int TIMEOUT = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_hold,
    output logic          load_done,
    output logic [AW:0]   word_count,
    output logic          mem_full,
    output logic          overflow_err
);

    // Timer must be able to hold TIMEOUT-1; the expiry test fires on the
    // TIMEOUT-th consecutive idle cycle.
    localparam int          TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [AW:0]   LAST_WORD  = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0]   WC_ONE     = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [31:0]     asm_q, asm_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [AW:0]     word_count_q, word_count_d;
    logic            mem_full_q, mem_full_d;
    logic            overflow_q, overflow_d;
    logic            flush_q, flush_d;

    logic            ready_int;
    logic            accept;
    logic            timer_expire;
    logic [3:0]      lane_we;
    logic [31:0]     asm_load;

    // Handshake: bytes are taken only while collecting or draining.
    assign ready_int    = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign accept       = byte_valid && ready_int;
    assign timer_expire = !accept && (timer_q == TIMER_LAST);

    // Per-lane byte steering: byte k of a word lands in bits [8k+7:8k].
    // Unwritten upper lanes stay zero, which gives the zero-padding for a
    // flushed partial word for free.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_we[gi] = accept && (state_q == S_LOAD) && (byte_idx_q == 2'(gi));
        assign asm_load[8*gi +: 8] = lane_we[gi] ? byte_data : asm_q[8*gi +: 8];
    end

    // Outputs decoded from the current state; address/data are zeroed
    // whenever no write is being issued.
    assign byte_ready   = ready_int;
    assign cpu_hold     = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_DRAIN);
    assign mem_we       = (state_q == S_WRITE);
    assign mem_addr     = mem_we ? word_count_q[AW-1:0] : '0;
    assign mem_wdata    = mem_we ? asm_q : '0;
    assign load_done    = (state_q == S_DONE);
    assign word_count   = word_count_q;
    assign mem_full     = mem_full_q;
    assign overflow_err = overflow_q;

    // Next-state and datapath update for the session FSM.
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        timer_d      = timer_q;
        word_count_d = word_count_q;
        mem_full_d   = mem_full_q;
        overflow_d   = overflow_q;
        flush_d      = flush_q;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d      = S_LOAD;
                    word_count_d = '0;
                    byte_idx_d   = '0;
                    asm_d        = '0;
                    timer_d      = '0;
                    mem_full_d   = 1'b0;
                    overflow_d   = 1'b0;
                    flush_d      = 1'b0;
                end
            end

            S_LOAD: begin
                if (accept) begin
                    asm_d      = asm_load;
                    byte_idx_d = byte_idx_q + 2'd1;
                    timer_d    = '0;
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end else if (timer_expire) begin
                    if (byte_idx_q == 2'd0) begin
                        state_d = S_DONE;
                    end else begin
                        // Partial word: write it out once, then finish.
                        flush_d = 1'b1;
                        state_d = S_WRITE;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            S_WRITE: begin
                word_count_d = word_count_q + WC_ONE;
                byte_idx_d   = '0;
                asm_d        = '0;
                timer_d      = '0;
                flush_d      = 1'b0;
                if (word_count_q == LAST_WORD) begin
                    mem_full_d = 1'b1;
                    state_d    = S_DRAIN;
                end else if (flush_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end

            S_DRAIN: begin
                // Memory is full: keep consuming bytes so the sender is not
                // stalled, but remember that data was lost.
                if (accept) begin
                    overflow_d = 1'b1;
                    timer_d    = '0;
                end else if (timer_expire) begin
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset that aborts any session.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            timer_q      <= '0;
            word_count_q <= '0;
            mem_full_q   <= 1'b0;
            overflow_q   <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            timer_q      <= timer_d;
            word_count_q <= word_count_d;
            mem_full_q   <= mem_full_d;
            overflow_q   <= overflow_d;
            flush_q      <= flush_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-level model pushes expected
// memory writes and session-end word counts into queues; a negedge monitor
// pops and compares them as the DUT produces writes and done pulses.
module tb_imem_loader;

    localparam int DEPTH   = 4;
    localparam int AW      = 2;
    localparam int TIMEOUT = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic [AW:0]   word_count;
    logic          mem_full;
    logic          overflow_err;

    imem_loader #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .word_count  (word_count),
        .mem_full    (mem_full),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_wq[$];
    int  exp_dq[$];
    int  we_cyc[$];
    int  cyc      = 0;
    int  done_cyc = 0;
    int  done_cnt = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    // Byte-level reference model state.
    int          m_wc;
    int          m_nb;
    logic [31:0] m_word;
    bit          m_full;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every write and every done pulse with the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                we_cyc.push_back(cyc);
                $display("write addr=%0d data=0x%08h cycle=%0d", mem_addr, mem_wdata, cyc);
                check_eq("we_bready", byte_ready, 0);
                check_eq("we_hold", cpu_hold, 1);
                if (exp_wq.size() == 0) begin
                    check_eq("unexp_we", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wq.pop_front();
                    check_eq("we_addr", mem_addr, e.addr);
                    check_eq("we_data", mem_wdata, e.data);
                end
            end
            if (load_done) begin
                done_cyc = cyc;
                done_cnt++;
                $display("done word_count=%0d cycle=%0d", word_count, cyc);
                check_eq("done_hold", cpu_hold, 0);
                if (exp_dq.size() == 0) check_eq("unexp_done", 1, 0);
                else                    check_eq("done_wc", word_count, exp_dq.pop_front());
            end
        end
    end

    task automatic model_start();
        m_wc   = 0;
        m_nb   = 0;
        m_word = '0;
        m_full = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_full) begin
            m_word[8*m_nb +: 8] = b;
            m_nb++;
            if (m_nb == 4) begin
                exp_wq.push_back('{m_wc, m_word});
                m_wc++;
                m_nb   = 0;
                m_word = '0;
                if (m_wc == DEPTH) m_full = 1'b1;
            end
        end
    endtask

    task automatic model_end();
        if (!m_full && m_nb != 0) begin
            exp_wq.push_back('{m_wc, m_word});
            m_wc++;
        end
        exp_dq.push_back(m_wc);
    endtask

    task automatic start_session();
        model_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = byte_ready;
            @(posedge clk); #1;
        end
        if (!ok) check_eq("send_timeout", 0, 1);
        else     model_byte(b);
    endtask

    task automatic bus_idle();
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic wait_done();
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < 3 * TIMEOUT + 20 && done_cnt == n0; i++) begin
            @(posedge clk); #1;
        end
        if (done_cnt == n0) check_eq("done_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_bready"}, byte_ready, 0);
        check_eq({tag, "_we"}, mem_we, 0);
        check_eq({tag, "_addr"}, mem_addr, 0);
        check_eq({tag, "_wdata"}, mem_wdata, 0);
        check_eq({tag, "_hold"}, cpu_hold, 0);
        check_eq({tag, "_done"}, load_done, 0);
        check_eq({tag, "_wc"}, word_count, 0);
        check_eq({tag, "_full"}, mem_full, 0);
        check_eq({tag, "_ovf"}, overflow_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [7:0] basic_bytes [8];
        basic_bytes = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h08, 8'h10, 8'h00};

        reset      = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        model_start();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic load with byte_valid held high: back-pressure in WRITE.
        start_session();
        s0 = cyc;
        we_cyc.delete();
        foreach (basic_bytes[i]) send_byte(basic_bytes[i]);
        bus_idle();
        model_end();
        wait_done();
        check_eq("basic_wc", word_count, 2);
        check_eq("basic_hold_after", cpu_hold, 0);
        check_eq("bp_nwr", we_cyc.size(), 2);
        if (we_cyc.size() == 2) check_eq("bp_cycles", we_cyc[1] - s0, 9);

        // Partial word flushed with zero padding after the idle timeout.
        start_session();
        s0 = cyc;
        we_cyc.delete();
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        bus_idle();
        model_end();
        wait_done();
        check_eq("flush_wc", word_count, 1);
        check_eq("flush_nwr", we_cyc.size(), 1);
        if (we_cyc.size() == 1) check_eq("flush_cyc", we_cyc[0] - s0, TIMEOUT + 3);

        // Fill every address, then overflow with two extra bytes.
        start_session();
        for (int i = 0; i < 16; i++) send_byte(8'(i * 37 + 5));
        bus_idle();
        @(posedge clk); #1;
        check_eq("fill_full", mem_full, 1);
        check_eq("fill_ovf_pre", overflow_err, 0);
        check_eq("fill_hold", cpu_hold, 1);
        send_byte(8'hE1);
        send_byte(8'hE2);
        bus_idle();
        check_eq("fill_ovf", overflow_err, 1);
        model_end();
        wait_done();
        check_eq("fill_wc", word_count, 4);
        check_eq("fill_full_held", mem_full, 1);
        check_eq("fill_ovf_held", overflow_err, 1);

        // New session clears sticky flags; then reset mid-word aborts it.
        start_session();
        @(negedge clk);
        check_eq("restart_full", mem_full, 0);
        check_eq("restart_ovf", overflow_err, 0);
        check_eq("restart_wc", word_count, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i));
        bus_idle();
        reset  = 1'b1;
        m_nb   = 0;
        m_word = '0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (TIMEOUT + 4) @(posedge clk);
        #1;
        check_eq("midrst_wq_empty", exp_wq.size(), 0);
        check_eq("midrst_dq_empty", exp_dq.size(), 0);
        start_session();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        bus_idle();
        model_end();
        wait_done();
        check_eq("after_rst_wc", word_count, 1);

        // Empty session with a second load_start pulse that must be ignored.
        start_session();
        s0 = cyc;
        we_cyc.delete();
        repeat (4) @(posedge clk);
        #1;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        model_end();
        wait_done();
        check_eq("empty_cyc", done_cyc - s0, TIMEOUT);
        check_eq("empty_wc", word_count, 0);
        check_eq("empty_nwr", we_cyc.size(), 0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("final_wq_empty", exp_wq.size(), 0);
        check_eq("final_dq_empty", exp_dq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
